// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard with issue stall, flush and drain handshake
module reg_scoreboard #(
  parameter int INDEX_WIDTH = 3,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [INDEX_WIDTH-1:0]    issue_rd,
  input  logic                      issue_use_rs1,
  input  logic [INDEX_WIDTH-1:0]    issue_rs1,
  input  logic                      issue_use_rs2,
  input  logic [INDEX_WIDTH-1:0]    issue_rs2,
  output logic                      stall,
  output logic                      issue_accept,
  input  logic                      wb_valid,
  input  logic [INDEX_WIDTH-1:0]    wb_rd,
  input  logic                      flush,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic [(1<<INDEX_WIDTH)-1:0] busy,
  output logic                      wb_err
);
  localparam int NREG = 1 << INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NREG];
  logic [CNT_WIDTH-1:0]  cnt_d [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  drain_done_q, drain_done_d;
  logic                  wb_err_q, wb_err_d;
  logic                  haz;

  // Only registered counts feed the hazard: a same-cycle WB cannot bypass the stale regfile read.
  always_comb begin
    haz = (issue_use_rs1 && (cnt_q[issue_rs1] != '0)) ||
          (issue_use_rs2 && (cnt_q[issue_rs2] != '0)) ||
          (issue_we      && (cnt_q[issue_rd]  == CMAX));
    stall        = issue_valid && (haz || (state_q != ST_RUN));
    issue_accept = issue_valid && !stall;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      // busy_q mirrors cnt_q != 0, so it doubles as the registered all-idle test
      ST_DRAIN: if (!drain_req) state_d = ST_RUN;
                else if (busy_q == '0) state_d = ST_DONE;
      ST_DONE:  if (!drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    drain_done_d = (state_d == ST_DONE);
  end

  always_comb begin
    logic inc, dec;
    wb_err_d = wb_err_q || (wb_valid && (cnt_q[wb_rd] == '0));
    for (int i = 0; i < NREG; i++) begin
      inc = issue_accept && issue_we && (issue_rd == INDEX_WIDTH'(i));
      dec = wb_valid && (wb_rd == INDEX_WIDTH'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (flush)            cnt_d[i] = '0;
      else if (inc && !dec) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      busy_q       <= '0;
      drain_done_q <= 1'b0;
      wb_err_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
      wb_err_q     <= wb_err_d;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy       = busy_q;
  assign drain_done = drain_done_q;
  assign wb_err     = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_we, issue_use_rs1, issue_use_rs2;
  logic [2:0] issue_rd, issue_rs1, issue_rs2;
  logic       stall, issue_accept;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic       flush, drain_req, drain_done, wb_err;
  logic [7:0] busy;
  int total = 0;
  int bad = 0;

  reg_scoreboard #(.INDEX_WIDTH(3), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_use_rs1(issue_use_rs1), .issue_rs1(issue_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_rs2(issue_rs2),
    .stall(stall), .issue_accept(issue_accept),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .drain_req(drain_req), .drain_done(drain_done),
    .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_rd = 0;
    issue_use_rs1 = 0; issue_rs1 = 0; issue_use_rs2 = 0; issue_rs2 = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic put_write(input logic [2:0] rd);
    issue_valid = 1; issue_we = 1; issue_rd = rd;
  endtask

  task automatic test_reset();
    idle(); drain_req = 0; rst = 1;
    step(); step();
    rst = 0;
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy got=%h exp=00", busy); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%b exp=0", drain_done); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
  endtask

  task automatic test_raw();
    put_write(3'd3);
    #1;
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL raw_first_accept got=%b exp=1", issue_accept); end
    step(); idle();
    total++; if (busy !== 8'h08) begin bad++; $display("FAIL raw_busy_set got=%h exp=08", busy); end
    issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 3'd3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", stall); end
    step();
    wb_valid = 1; wb_rd = 3'd3;
    #1;
    total++; if (stall !== 1'b1 || issue_accept !== 1'b0) begin bad++; $display("FAIL raw_stall_wb_cycle got=%b/%b exp=1/0", stall, issue_accept); end
    step();
    wb_valid = 0;
    #1;
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL raw_accept_after_wb got=%b exp=1", issue_accept); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL raw_busy_clear got=%h exp=00", busy); end
    step(); idle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      put_write(3'd5);
      #1;
      total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL sat_accept_%0d got=%b exp=1", k, issue_accept); end
      step();
    end
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_fourth_stall got=%b exp=1", stall); end
    wb_valid = 1; wb_rd = 3'd5;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall_wb_cycle got=%b exp=1", stall); end
    step();
    wb_valid = 0;
    #1;
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL sat_fourth_accept got=%b exp=1", issue_accept); end
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_rd = 3'd5;
      step();
    end
    idle();
    total++; if (busy !== 8'h00 || wb_err !== 1'b0) begin bad++; $display("FAIL sat_drained got=%h/%b exp=00/0", busy, wb_err); end
  endtask

  task automatic test_simultaneous();
    put_write(3'd2);
    step();
    put_write(3'd2); wb_valid = 1; wb_rd = 3'd2;
    #1;
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL simul_accept got=%b exp=1", issue_accept); end
    step(); idle();
    total++; if (busy !== 8'h04) begin bad++; $display("FAIL simul_busy got=%h exp=04", busy); end
    wb_valid = 1; wb_rd = 3'd2;
    step(); idle();
    total++; if (busy !== 8'h00 || wb_err !== 1'b0) begin bad++; $display("FAIL simul_count_one got=%h/%b exp=00/0", busy, wb_err); end
  endtask

  task automatic test_spurious_wb();
    put_write(3'd1);
    step(); idle();
    wb_valid = 1; wb_rd = 3'd6;
    step(); idle();
    total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL spur_err_set got=%b exp=1", wb_err); end
    total++; if (busy !== 8'h02) begin bad++; $display("FAIL spur_busy_unchanged got=%h exp=02", busy); end
    wb_valid = 1; wb_rd = 3'd1;
    step(); idle(); step();
    total++; if (wb_err !== 1'b1 || busy !== 8'h00) begin bad++; $display("FAIL spur_err_sticky got=%b/%h exp=1/00", wb_err, busy); end
  endtask

  task automatic test_drain();
    put_write(3'd1); step();
    put_write(3'd4); step(); idle();
    drain_req = 1;
    step();
    issue_valid = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL drain_stall got=%b exp=1", stall); end
    wb_valid = 1; wb_rd = 3'd1; step();
    wb_rd = 3'd4; step();
    wb_valid = 0;
    total++; if (busy !== 8'h00 || drain_done !== 1'b0) begin bad++; $display("FAIL drain_not_yet got=%h/%b exp=00/0", busy, drain_done); end
    step();
    total++; if (drain_done !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL drain_done got=%b/%b exp=1/1", drain_done, stall); end
    drain_req = 0;
    step();
    total++; if (drain_done !== 1'b0 || issue_accept !== 1'b1) begin bad++; $display("FAIL drain_release got=%b/%b exp=0/1", drain_done, issue_accept); end
    idle();
  endtask

  task automatic test_flush_reset();
    put_write(3'd0); step();
    put_write(3'd1); step();
    put_write(3'd2); step();
    total++; if (busy !== 8'h07) begin bad++; $display("FAIL flush_pre_busy got=%h exp=07", busy); end
    put_write(3'd7); flush = 1;
    #1;
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL flush_issue_eval got=%b exp=1", issue_accept); end
    step(); idle();
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL flush_busy got=%h exp=00", busy); end
    put_write(3'd3); step(); idle();
    drain_req = 1; step();
    flush = 1; step(); flush = 0;
    total++; if (busy !== 8'h00 || drain_done !== 1'b0) begin bad++; $display("FAIL flush_in_drain got=%h/%b exp=00/0", busy, drain_done); end
    step();
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL flush_drain_done got=%b exp=1", drain_done); end
    drain_req = 0; step();
    put_write(3'd4); step(); idle();
    drain_req = 1; step();
    rst = 1; step();
    issue_valid = 1;
    #1;
    total++; if (busy !== 8'h00 || drain_done !== 1'b0 || wb_err !== 1'b0) begin bad++; $display("FAIL rst_in_drain got=%h/%b/%b exp=00/0/0", busy, drain_done, wb_err); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_fsm_run got=%b exp=0", stall); end
    rst = 0; drain_req = 0; idle(); step();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_spurious_wb();
    test_drain();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
